// File: rtl/transpad_req_ctrl.sv
// transpad_req_ctrl: initiator-side start/stop sequencer for the transpad control unit.
//
// Accepts start/stop commands from the host, asserts start_req_ok until the transpad
// leaves its config state, tracks the active phase, and asserts stop_req when the host
// asks for it or when the active-cycle budget runs out. Busy/done/error status and every
// request output are registered.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid       host command strobe
//   cmd_ready       command can be accepted this cycle (RUN: stop only)
//   cmd_stop        0 = start, 1 = stop
//   cmd_budget      max tp_act cycles for a start (0 = unlimited)
//   tp_conf         transpad is in config state
//   tp_act          transpad is translating
//   start_req_ok    start request to transpad
//   stop_req        stop request to transpad
//   busy            sequence in progress
//   done            one-cycle pulse on normal completion
//   err_timeout     sticky timeout flag, cleared by the next accepted start
//
// Optional feature (macro TRANSPAD_REQ_STATS_EN):
//   act_cycles      saturating count of tp_act cycles seen in RUN
//   stop_forced     the sequence went through STOP
module transpad_req_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned REQ_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_stop,
    input  logic [CNT_W-1:0] cmd_budget,
    input  logic             tp_conf,
    input  logic             tp_act,
    output logic             start_req_ok,
    output logic             stop_req,
    output logic             busy,
    output logic             done,
    output logic             err_timeout
`ifdef TRANSPAD_REQ_STATS_EN
    ,
    output logic [CNT_W-1:0] act_cycles,
    output logic             stop_forced
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRun,
        StStop,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] TmoLim = CNT_W'(REQ_TIMEOUT);

    state_e           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] act_q;
    logic [CNT_W-1:0] budget_q;
`ifdef TRANSPAD_REQ_STATS_EN
    logic             forced_q;
`endif

    logic [CNT_W-1:0] timer_inc;
    logic             tmo_hit;
    logic [CNT_W-1:0] act_next;
    logic             start_acc;
    logic             stop_acc;
    logic             budget_hit;

    // Only a stop may be taken in RUN; a start offered there is held off.
    always_comb begin
        cmd_ready = (state_q == StIdle) || ((state_q == StRun) && cmd_stop);
    end

    always_comb begin
        start_acc  = cmd_valid && cmd_ready && !cmd_stop;
        stop_acc   = cmd_valid && cmd_ready && cmd_stop;
        // Timer saturates at the limit; expiry fires on the cycle it would reach it.
        timer_inc  = (timer_q >= TmoLim) ? TmoLim : timer_q + CNT_W'(1);
        tmo_hit    = (timer_inc == TmoLim);
        act_next   = act_q;
        if (tp_act && (act_q != '1)) begin
            act_next = act_q + CNT_W'(1);
        end
        // Compare against the updated count so the final active cycle triggers the stop.
        budget_hit = (budget_q != '0) && (act_next == budget_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            act_q        <= '0;
            budget_q     <= '0;
            start_req_ok <= 1'b0;
            stop_req     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
`ifdef TRANSPAD_REQ_STATS_EN
            forced_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_acc) begin
                        state_q      <= StReq;
                        timer_q      <= '0;
                        act_q        <= '0;
                        budget_q     <= cmd_budget;
                        start_req_ok <= 1'b1;
                        busy         <= 1'b1;
                        err_timeout  <= 1'b0;
`ifdef TRANSPAD_REQ_STATS_EN
                        forced_q     <= 1'b0;
`endif
                    end
                end
                StReq: begin
                    if (!tp_conf) begin
                        state_q      <= StRun;
                        timer_q      <= '0;
                        start_req_ok <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q      <= StIdle;
                        timer_q      <= '0;
                        start_req_ok <= 1'b0;
                        busy         <= 1'b0;
                        err_timeout  <= 1'b1;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StRun: begin
                    act_q <= act_next;
                    // Natural end has priority over a stop or budget hit in the same cycle.
                    if (tp_conf) begin
                        state_q <= StDone;
                        timer_q <= '0;
                        done    <= 1'b1;
                    end else if (stop_acc || budget_hit) begin
                        state_q  <= StStop;
                        timer_q  <= '0;
                        stop_req <= 1'b1;
`ifdef TRANSPAD_REQ_STATS_EN
                        forced_q <= 1'b1;
`endif
                    end
                end
                StStop: begin
                    if (tp_conf) begin
                        state_q  <= StDone;
                        timer_q  <= '0;
                        stop_req <= 1'b0;
                        done     <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q     <= StIdle;
                        timer_q     <= '0;
                        stop_req    <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    timer_q <= '0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q      <= StIdle;
                    timer_q      <= '0;
                    start_req_ok <= 1'b0;
                    stop_req     <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRANSPAD_REQ_STATS_EN
    assign act_cycles  = act_q;
    assign stop_forced = forced_q;
`endif

endmodule

// File: tb/tb_transpad_req_ctrl.sv
// Self-checking bench for transpad_req_ctrl: directed scenarios, a cycle-level
// behavioural model compared every cycle, and literal expectations per scenario.
module tb_transpad_req_ctrl;

    localparam int CNT_W   = 16;
    localparam int TMO     = 255;
    localparam int ACT_MAX = (1 << CNT_W) - 1;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_RUN  = 2;
    localparam int P_STOP = 3;
    localparam int P_DONE = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_stop;
    logic [CNT_W-1:0] cmd_budget;
    logic             tp_conf;
    logic             tp_act;
    logic             start_req_ok;
    logic             stop_req;
    logic             busy;
    logic             done;
    logic             err_timeout;
`ifdef TRANSPAD_REQ_STATS_EN
    logic [CNT_W-1:0] act_cycles;
    logic             stop_forced;
`endif

    transpad_req_ctrl #(
        .CNT_W      (CNT_W),
        .REQ_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_stop    (cmd_stop),
        .cmd_budget  (cmd_budget),
        .tp_conf     (tp_conf),
        .tp_act      (tp_act),
        .start_req_ok(start_req_ok),
        .stop_req    (stop_req),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout)
`ifdef TRANSPAD_REQ_STATS_EN
        ,
        .act_cycles  (act_cycles),
        .stop_forced (stop_forced)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: which phase the sequence is in plus a few tallies.
    int m_ph, m_age, m_bud, m_act;
    bit m_err, m_forced;

    always @(posedge clk) begin
        int a;
        a = m_act + (tp_act ? 1 : 0);
        if (a > ACT_MAX) a = ACT_MAX;
        if (rst) begin
            m_ph <= P_IDLE; m_age <= 0; m_bud <= 0; m_act <= 0; m_err <= 0; m_forced <= 0;
        end else begin
            case (m_ph)
                P_IDLE: if (cmd_valid && !cmd_stop) begin
                    m_ph <= P_REQ; m_age <= 0; m_err <= 0; m_act <= 0;
                    m_bud <= int'(cmd_budget); m_forced <= 0;
                end
                P_REQ: begin
                    if (!tp_conf) m_ph <= P_RUN;
                    else if (m_age + 1 >= TMO) begin m_ph <= P_IDLE; m_err <= 1; end
                    else m_age <= m_age + 1;
                end
                P_RUN: begin
                    m_act <= a;
                    if (tp_conf) m_ph <= P_DONE;
                    else if ((cmd_valid && cmd_stop) || (m_bud != 0 && a == m_bud)) begin
                        m_ph <= P_STOP; m_age <= 0; m_forced <= 1;
                    end
                end
                P_STOP: begin
                    if (tp_conf) m_ph <= P_DONE;
                    else if (m_age + 1 >= TMO) begin m_ph <= P_IDLE; m_err <= 1; end
                    else m_age <= m_age + 1;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;
    int n_sro = 0, n_stp = 0, n_done = 0;

    task automatic chk(string name, int got, int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Advance one clock, then compare every output with the model.
    task automatic step();
        logic [5:0] got, want;
        @(posedge clk);
        #1;
        if (chk_en) begin
            got  = {cmd_ready, start_req_ok, stop_req, busy, done, err_timeout};
            want = {(m_ph == P_IDLE) || (m_ph == P_RUN && cmd_stop), m_ph == P_REQ,
                    m_ph == P_STOP, m_ph != P_IDLE, m_ph == P_DONE, m_err};
            n_chk++;
            if (got !== want) begin
                n_err++;
                $display("FAIL model_outputs t=%0t rdy/sro/stp/busy/done/err got=%b want=%b",
                         $time, got, want);
            end
`ifdef TRANSPAD_REQ_STATS_EN
            n_chk++;
            if (int'(act_cycles) != m_act || stop_forced !== m_forced) begin
                n_err++;
                $display("FAIL model_stats t=%0t act/forced got=%0d/%b want=%0d/%b",
                         $time, act_cycles, stop_forced, m_act, m_forced);
            end
`endif
        end
        if (start_req_ok) n_sro++;
        if (stop_req) n_stp++;
        if (done) n_done++;
    endtask

    task automatic start_cmd(int b);
        cmd_valid = 1; cmd_stop = 0; cmd_budget = CNT_W'(b);
        step();
        cmd_valid = 0;
    endtask

    initial begin
        int s_sro, s_stp, s_done;
        int i;
        rst = 1; cmd_valid = 0; cmd_stop = 0; cmd_budget = '0; tp_conf = 1; tp_act = 0;
        step(); step();
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_sro", start_req_ok, 0);
        chk("rst_stop", stop_req, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 0;
        step();

        // Stop in IDLE is ignored.
        cmd_valid = 1; cmd_stop = 1; step(); cmd_valid = 0; cmd_stop = 0;
        chk("idle_stop_ignored", busy, 0);

        // 1: natural sequence, budget unlimited.
        s_sro = n_sro; s_stp = n_stp; s_done = n_done;
        start_cmd(0); step(); step();
        tp_conf = 0; step();
        tp_act = 1;
        repeat (10) step();
        tp_act = 0; tp_conf = 1; step();
        chk("t1_done_now", done, 1);
        step();
        chk("t1_sro_cycles", n_sro - s_sro, 3);
        chk("t1_done_pulses", n_done - s_done, 1);
        chk("t1_no_stop", n_stp - s_stp, 0);
        chk("t1_busy_after", busy, 0);
`ifdef TRANSPAD_REQ_STATS_EN
        chk("t1_act", int'(act_cycles), 10);
        chk("t1_forced", stop_forced, 0);
`endif

        // 2: budget of 5 forces a stop.
        start_cmd(5); step(); step();
        tp_conf = 0; step();
        tp_act = 1;
        repeat (4) step();
        chk("t2_no_stop_yet", stop_req, 0);
        step();
        chk("t2_stop_at_5", stop_req, 1);
        step(); step();
        tp_conf = 1; tp_act = 0; step();
        chk("t2_done", done, 1);
        chk("t2_stop_dropped", stop_req, 0);
`ifdef TRANSPAD_REQ_STATS_EN
        chk("t2_act", int'(act_cycles), 5);
        chk("t2_forced", stop_forced, 1);
`endif
        step();

        // 3: request timeout with tp_conf stuck high.
        s_sro = n_sro; s_done = n_done;
        start_cmd(0);
        for (i = 0; i < 300 && !err_timeout; i++) step();
        chk("t3_err_set", err_timeout, 1);
        chk("t3_sro_cycles", n_sro - s_sro, TMO);
        chk("t3_no_done", n_done - s_done, 0);
        chk("t3_idle", busy, 0);
        step();
        start_cmd(0);
        chk("t3_err_cleared", err_timeout, 0);
        tp_conf = 0; step();
        tp_conf = 1; step(); step();

        // 4: start held off in RUN; stop coinciding with tp_conf rise ends naturally.
        s_stp = n_stp;
        start_cmd(0); step();
        tp_conf = 0; step(); step();
        cmd_valid = 1; cmd_stop = 0; #1;
        chk("t4_start_held_off", cmd_ready, 0);
        step();
        chk("t4_still_run", busy, 1);
        cmd_stop = 1; tp_conf = 1; #1;
        chk("t4_stop_ready", cmd_ready, 1);
        step();
        cmd_valid = 0; cmd_stop = 0;
        chk("t4_done", done, 1);
        chk("t4_no_stop", n_stp - s_stp, 0);
        step();

        // 5: tp_act gaps do not end RUN.
        start_cmd(0); step();
        tp_conf = 0; step();
        tp_act = 1; repeat (4) step();
        tp_act = 0; repeat (2) step();
        tp_act = 1; repeat (4) step();
        tp_act = 0;
        chk("t5_still_busy", busy, 1);
        chk("t5_not_done", done, 0);
`ifdef TRANSPAD_REQ_STATS_EN
        chk("t5_act", int'(act_cycles), 8);
`endif
        tp_conf = 1; step(); step();

        // 6: reset during STOP.
        s_done = n_done;
        start_cmd(0); step();
        tp_conf = 0; step();
        cmd_valid = 1; cmd_stop = 1; step();
        cmd_valid = 0; cmd_stop = 0; step();
        chk("t6_in_stop", stop_req, 1);
        rst = 1; step(); rst = 0;
        chk("t6_stop_dropped", stop_req, 0);
        chk("t6_busy_dropped", busy, 0);
        chk("t6_err_clear", err_timeout, 0);
        tp_conf = 1; step(); step();
        chk("t6_no_done", n_done - s_done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
